// File: rtl/weight_ram_ctrl.sv
// weight_ram_ctrl: LOAD/RUN sequencer for the convolution weight RAM.
// Optional macro WEIGHT_CHECKSUM_EN adds the wsum output (sum of loaded weights).
`default_nettype none

module weight_ram_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_TAPS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              run_start,
  input  logic [15:0]       run_count,
  input  logic              w_valid,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ready,
  input  logic              mac_stall,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              tap_valid,
  output logic [ADDR_W-1:0] tap_idx,
  output logic              tap_last,
  output logic              busy,
`ifdef WEIGHT_CHECKSUM_EN
  output logic [DATA_W-1:0] wsum,
`endif
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic [15:0]       pix_q, pix_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       pix_inc;
  logic              tap_valid_q;
  logic [ADDR_W-1:0] tap_idx_q;
  logic              tap_last_q;

  assign pix_inc = pix_q + 16'd1;

  // RAM-side strobes are gated so every output is 0 while idle or in reset.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    pix_d     = pix_q;
    cnt_d     = cnt_q;
    w_ready   = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_re    = 1'b0;
    ram_raddr = '0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          wcnt_d  = '0;
        end else if (run_start) begin
          state_d = S_RUN;
          rcnt_d  = '0;
          pix_d   = '0;
          cnt_d   = run_count;
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          ram_we    = 1'b1;
          ram_waddr = wcnt_q;
          ram_wdata = w_data;
          if (wcnt_q == LAST_TAP) begin
            state_d = S_DONE;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == 16'd0) begin
          state_d = S_DONE;
        end else if (!mac_stall) begin
          ram_re    = 1'b1;
          ram_raddr = rcnt_q;
          if (rcnt_q == LAST_TAP) begin
            rcnt_d = '0;
            pix_d  = pix_inc;
            if (pix_inc == cnt_q) begin
              state_d = S_DONE;
            end
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      pix_q       <= '0;
      cnt_q       <= '0;
      tap_valid_q <= 1'b0;
      tap_idx_q   <= '0;
      tap_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      pix_q       <= pix_d;
      cnt_q       <= cnt_d;
      tap_valid_q <= ram_re;
      tap_idx_q   <= ram_raddr;
      tap_last_q  <= ram_re && (ram_raddr == LAST_TAP);
    end
  end

  assign tap_valid = tap_valid_q;
  assign tap_idx   = tap_idx_q;
  assign tap_last  = tap_last_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

`ifdef WEIGHT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if ((state_q == S_IDLE) && load_start) begin
      sum_q <= '0;
    end else if (ram_we) begin
      sum_q <= sum_q + w_data;
    end
  end

  assign wsum = sum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_weight_ram_ctrl.sv
// Self-checking bench for weight_ram_ctrl with a behavioural RAM and tap-sequence model.
`default_nettype none

module tb_weight_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        run_start = 1'b0;
  logic [15:0] run_count = '0;
  logic        w_valid = 1'b0;
  logic [15:0] w_data = '0;
  logic        w_ready;
  logic        mac_stall = 1'b0;
  logic        ram_we;
  logic [2:0]  ram_waddr;
  logic [15:0] ram_wdata;
  logic        ram_re;
  logic [2:0]  ram_raddr;
  logic        tap_valid;
  logic [2:0]  tap_idx;
  logic        tap_last;
  logic        busy;
  logic        done;
`ifdef WEIGHT_CHECKSUM_EN
  logic [15:0] wsum;
`endif

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [0:7];
  logic [15:0] rdata;
  logic [15:0] wref [0:4];

  weight_ram_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .run_start(run_start),
    .run_count(run_count), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .mac_stall(mac_stall), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .tap_valid(tap_valid), .tap_idx(tap_idx),
    .tap_last(tap_last), .busy(busy),
`ifdef WEIGHT_CHECKSUM_EN
    .wsum(wsum),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural weight RAM: synchronous write, one-cycle registered read, cleared by rst_n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (ram_re) rdata <= mem[ram_raddr];
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({w_ready, ram_we, ram_re, tap_valid, tap_last, busy, done} !== 7'b0 ||
        ram_waddr !== 3'd0 || ram_raddr !== 3'd0 || ram_wdata !== 16'd0 || tap_idx !== 3'd0) begin
      fails++;
      $display("FAIL reset_outputs: got flags=%b waddr=%0d raddr=%0d wdata=%h idx=%0d, need all 0",
               {w_ready, ram_we, ram_re, tap_valid, tap_last, busy, done}, ram_waddr, ram_raddr, ram_wdata, tap_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b done=%b, need 0 0", busy, done);
    end
  endtask

  // mode 0: back-to-back fixed weights, 1: valid on alternate cycles, 2: random valid and stray run_start
  task automatic do_load(input int mode, input bit both);
    logic [15:0] w [0:4];
    logic [15:0] sum;
    int acc, cyc, first_we, done_cyc;
    bit vld, exp_rdy, exp_done, done_seen, post;
    acc = 0; first_we = -1; done_cyc = -1; done_seen = 0; post = 0; sum = '0;
    for (int i = 0; i < 5; i++) begin
      w[i] = (mode == 0) ? 16'(16'h0011 * (i + 1)) : 16'($urandom);
    end
    if (mode == 1) begin
      w[0] = 16'hFFFF;
      w[1] = 16'h0002;
    end
    for (int i = 0; i < 5; i++) sum = sum + w[i];
    @(negedge clk);
    load_start = 1'b1; run_start = both; run_count = 16'd3; w_valid = 1'b0;
    for (cyc = 1; cyc < 80 && !post; cyc++) begin
      @(negedge clk);
      load_start = 1'b0;
      run_start  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      case (mode)
        0: vld = (acc < 5);
        1: vld = (cyc % 2 == 1);
        default: vld = 1'($urandom_range(0, 1));
      endcase
      w_valid = vld;
      w_data  = (acc < 5) ? w[acc] : 16'hDEAD;
      #1;
      if (done_seen) begin
        post = 1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || w_ready !== 1'b0 || ram_we !== 1'b0) begin
          fails++;
          $display("FAIL load_after_done: got busy=%b done=%b rdy=%b we=%b, need 0 0 0 0", busy, done, w_ready, ram_we);
        end
      end else begin
        exp_rdy  = (acc < 5);
        exp_done = (acc == 5);
        tests++;
        if (w_ready !== exp_rdy || ram_we !== (vld && exp_rdy) || ram_re !== 1'b0 ||
            done !== exp_done || busy !== exp_rdy) begin
          fails++;
          $display("FAIL load_ctl c%0d: got rdy=%b we=%b re=%b done=%b busy=%b, need %b %b 0 %b %b",
                   cyc, w_ready, ram_we, ram_re, done, busy, exp_rdy, vld && exp_rdy, exp_done, exp_rdy);
        end
        if (exp_done) begin
          done_seen = 1;
          done_cyc  = cyc;
        end
        if (vld && exp_rdy) begin
          tests++;
          if (ram_waddr !== 3'(acc) || ram_wdata !== w[acc]) begin
            fails++;
            $display("FAIL load_write #%0d: got addr=%0d data=%h, need %0d %h", acc, ram_waddr, ram_wdata, acc, w[acc]);
          end
          if (first_we < 0) first_we = cyc;
          wref[acc] = w[acc];
          acc++;
        end
      end
    end
    w_valid = 1'b0; run_start = 1'b0;
    tests++;
    if (!post) begin
      fails++;
      $display("FAIL load_timeout: got %0d weights accepted, need 5 and done", acc);
    end
    if (mode == 0) begin
      tests++;
      if (first_we !== 1 || done_cyc !== 6) begin
        fails++;
        $display("FAIL load_burst_timing: got first_we=%0d done_cyc=%0d, need 1 6", first_we, done_cyc);
      end
    end
`ifdef WEIGHT_CHECKSUM_EN
    tests++;
    if (wsum !== sum) begin
      fails++;
      $display("FAIL wsum: got %h, need %h", wsum, sum);
    end
`endif
  endtask

  // mode 0: no stall, 1: three stall cycles at tap 2, 2: random stall
  task automatic run_op(input int cnt, input int mode);
    int total, issued, seen, stall_left, cyc;
    bit prev_re, stall, exp_re, exp_done, finished;
    logic [2:0] prev_a;
    total = 5 * cnt; issued = 0; seen = 0; stall_left = 3;
    prev_re = 0; prev_a = '0; finished = 0;
    @(negedge clk);
    run_start = 1'b1; run_count = 16'(cnt); mac_stall = 1'b0;
    for (cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      run_start = 1'b0;
      stall = 1'b0;
      if (mode == 1 && issued % 5 == 2 && stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end
      if (mode == 2) stall = ($urandom_range(0, 3) == 0);
      mac_stall = stall;
      #1;
      tests++;
      if (tap_valid !== prev_re) begin
        fails++;
        $display("FAIL run_tap_valid c%0d: got %b, need %b", cyc, tap_valid, prev_re);
      end
      if (prev_re) begin
        seen++;
        tests++;
        if (tap_idx !== prev_a || tap_last !== (prev_a == 3'd4) || rdata !== wref[prev_a]) begin
          fails++;
          $display("FAIL run_tap #%0d: got idx=%0d last=%b data=%h, need %0d %b %h",
                   seen, tap_idx, tap_last, rdata, prev_a, prev_a == 3'd4, wref[prev_a]);
        end
      end
      exp_done = prev_re && (seen == total);
      exp_re   = (issued < total) && !stall;
      tests++;
      if (done !== exp_done || busy !== !exp_done || ram_re !== exp_re || ram_we !== 1'b0) begin
        fails++;
        $display("FAIL run_ctl c%0d: got done=%b busy=%b re=%b we=%b, need %b %b %b 0",
                 cyc, done, busy, ram_re, ram_we, exp_done, !exp_done, exp_re);
      end
      if (exp_re) begin
        tests++;
        if (ram_raddr !== 3'(issued % 5)) begin
          fails++;
          $display("FAIL run_raddr #%0d: got %0d, need %0d", issued, ram_raddr, issued % 5);
        end
        prev_a = 3'(issued % 5);
        issued++;
      end
      prev_re = exp_re;
      if (exp_done) finished = 1;
    end
    mac_stall = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (!finished || seen !== total || busy !== 1'b0 || done !== 1'b0 || tap_valid !== 1'b0) begin
      fails++;
      $display("FAIL run_end: got taps=%0d busy=%b done=%b tv=%b, need %0d 0 0 0", seen, busy, done, tap_valid, total);
    end
  endtask

  task automatic test_zero_run();
    @(negedge clk);
    run_start = 1'b1; run_count = 16'd0;
    @(negedge clk);
    run_start = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || ram_re !== 1'b0) begin
      fails++;
      $display("FAIL zero_run_enter: got busy=%b done=%b re=%b, need 1 0 0", busy, done, ram_re);
    end
    @(negedge clk);
    #1;
    tests++;
    if (done !== 1'b1 || ram_re !== 1'b0 || tap_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_run_done: got done=%b re=%b tv=%b, need 1 0 0", done, ram_re, tap_valid);
    end
    @(negedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL zero_run_idle: got busy=%b done=%b, need 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    run_start = 1'b1; run_count = 16'd3; mac_stall = 1'b0;
    repeat (4) begin
      @(negedge clk);
      run_start = 1'b0;
    end
    #1;
    tests++;
    if (ram_re !== 1'b1 || tap_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midrun_active: got re=%b tv=%b busy=%b, need 1 1 1", ram_re, tap_valid, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({w_ready, ram_we, ram_re, tap_valid, tap_last, busy, done} !== 7'b0 ||
        ram_raddr !== 3'd0 || tap_idx !== 3'd0) begin
      fails++;
      $display("FAIL midrun_async_reset: got flags=%b raddr=%0d idx=%0d, need all 0",
               {w_ready, ram_we, ram_re, tap_valid, tap_last, busy, done}, ram_raddr, tap_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || tap_valid !== 1'b0 || ram_re !== 1'b0) begin
      fails++;
      $display("FAIL midrun_idle: got busy=%b tv=%b re=%b, need 0 0 0", busy, tap_valid, ram_re);
    end
  endtask

  initial begin
    test_reset();
    do_load(0, 1'b0);       // test_load_burst
    run_op(2, 0);           // test_run_nostall
    run_op(2, 1);           // test_run_stall
    do_load(1, 1'b0);       // test_load_gaps
    run_op(3, 2);           // test_run_random
    do_load(2, 1'b1);       // test_start_collision
    run_op(1, 0);
    test_zero_run();
    test_reset_mid_run();
    do_load(2, 1'b0);       // test_back_to_back after reset
    run_op(2, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
